// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a scan-code FIFO, sticky error flags, frame watchdog and fill level.
// Optional saturating error counter enabled by defining PS2_RX_ERRCNT_EN.
module ps2_rx_fifo #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              nextdata_n,
  input  logic              err_clr,
  output logic [7:0]        data,
  output logic              ready,
  output logic              overflow,
  output logic              frame_err,
  output logic [ADDR_W:0]   level,
  output logic [7:0]        err_cnt
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned LVL_W    = ADDR_W + 1;
  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LAST_BIT = 10;

  logic [SYNC_STAGES-1:0] ck_sync;
  logic [SYNC_STAGES-1:0] dt_sync;
  logic [CNT_W-1:0]       bit_cnt;
  logic [9:0]             shift_q;
  logic [WD_W-1:0]        wd_cnt;
  logic [7:0]             mem [DEPTH];
  logic [ADDR_W-1:0]      w_ptr;
  logic [ADDR_W-1:0]      r_ptr;

  logic       strobe_c;
  logic       din_c;
  logic       frame_end_c;
  logic       frame_ok_c;
  logic       good_c;
  logic       bad_c;
  logic       timeout_c;
  logic       full_c;
  logic       pop_c;
  logic       push_c;
  logic       drop_c;
  logic [7:0] rx_byte_c;

  // Pin synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (clrn) begin
      ck_sync <= '1;
      dt_sync <= '1;
    end else begin
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], ps2_clk};
      dt_sync <= {dt_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Event decode for the current cycle.
  always_comb begin
    strobe_c    = ck_sync[SYNC_STAGES-1] & ~ck_sync[SYNC_STAGES-2];
    din_c       = dt_sync[SYNC_STAGES-1];
    frame_end_c = strobe_c && (bit_cnt == CNT_W'(LAST_BIT));
    // shift_q[0]=start, [8:1]=data, [9]=parity; din_c is the stop bit
    frame_ok_c  = ~shift_q[0] & din_c & (^shift_q[9:1]);
    rx_byte_c   = shift_q[8:1];
    good_c      = frame_end_c && frame_ok_c && !clrn;
    bad_c       = frame_end_c && !frame_ok_c && !clrn;
    timeout_c   = !clrn && !strobe_c && (bit_cnt != '0) &&
                  (wd_cnt == WD_W'(TIMEOUT_CYC));
    full_c      = (level == LVL_W'(DEPTH));
    pop_c       = ready && !nextdata_n && !clrn;
    push_c      = good_c && (!full_c || pop_c);
    drop_c      = good_c && full_c && !pop_c;
  end

  // Bit counter, frame shifter and watchdog.
  always_ff @(posedge clk) begin
    if (clrn) begin
      bit_cnt <= '0;
      shift_q <= '0;
      wd_cnt  <= '0;
    end else if (strobe_c) begin
      wd_cnt <= '0;
      if (bit_cnt == CNT_W'(LAST_BIT)) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        shift_q <= {din_c, shift_q[9:1]};
      end
    end else if (timeout_c) begin
      bit_cnt <= '0;
      wd_cnt  <= '0;
    end else if (bit_cnt != '0) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // Storage is left unreset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[w_ptr] <= rx_byte_c;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else begin
      if (push_c) begin
        w_ptr <= w_ptr + ADDR_W'(1);
      end
      if (pop_c) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky flags: a same-cycle error event beats err_clr.
  always_ff @(posedge clk) begin
    if (clrn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (bad_c || timeout_c) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

  assign ready = (level != '0);
  assign data  = mem[r_ptr];

`ifdef PS2_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic       err_evt_c;

  assign err_evt_c = bad_c || timeout_c || drop_c;

  // Coincident events count once; saturates at 255.
  always_ff @(posedge clk) begin
    if (clrn) begin
      err_cnt_q <= '0;
    end else if (err_evt_c && err_clr) begin
      err_cnt_q <= 8'd1;
    end else if (err_evt_c) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
